header_word_feeder: RTL and testbench
=====================================

Name: header_word_feeder

Overview:
- Upstream stage of the double-SHA-256 core. Buffers an 80-byte block header loaded a byte at a time.
- Answers the core's word requests (addr/rq in, data/rdy out) with header words plus the fixed SHA-256 padding for the 640-bit message.
- Holds a live nonce counter that replaces header word 19. Successive hashing attempts therefore need no header reload.

Parameters:
- NONCE_WORD, 19: word index served from the nonce counter instead of header storage.
- MSG_BITS, 640: message length placed in padding word 31.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous active-high reset
- load_start  input  1  pulse; restarts header load at byte 0
- load_valid  input  1  load_byte valid this cycle
- load_byte  input  8  header byte, big-endian within each word, byte 0 first
- hdr_valid  output  1  all 80 bytes loaded since last load_start
- rq  input  1  word request from hash core
- addr  input  5  requested word index 0..31
- data  output  32  requested word, valid while rdy=1
- rdy  output  1  one-cycle acknowledge
- nonce_inc  input  1  pulse; nonce <= nonce+1
- nonce  output  32  current nonce
- nonce_wrap  output  1  sticky; set on increment from 0xFFFFFFFF

Behaviour:
- Reset (async, immediate): hdr_valid=0, rdy=0, data=0, nonce=0, nonce_wrap=0, load count=0, service FSM=S_IDLE. Header storage is not cleared.
- Load path:
  - 7-bit byte counter. load_start sets count=0, clears hdr_valid and clears nonce_wrap. If load_valid is also high that cycle, the byte is written at index 0 and count becomes 1.
  - Each load_valid with count<80 writes byte[count] and increments count. Bytes 76..79 are written into the nonce register, big-endian, not into storage.
  - hdr_valid rises the cycle after byte 79 is written. load_valid with count=80 is ignored.
- Word map (addr -> data):
  - 0..18: stored header words.
  - NONCE_WORD: nonce.
  - 20: 0x80000000.
  - 21..30: 0x00000000.
  - 31: MSG_BITS (0x00000280).
- Service FSM:
  - S_IDLE: if rq=1 and hdr_valid=1, register data <= word(addr) and set rdy=1, then go to S_ACK. If rq=1 and hdr_valid=0, stall in S_IDLE with no response.
  - S_ACK: rdy=1 for exactly this cycle. Next edge rdy=0; go to S_WAITLOW.
  - S_WAITLOW: ignore rq until it is sampled low, then go to S_IDLE.
  - Latency: rq sampled at edge N gives rdy=1 and data valid during cycle N+1. data holds its value until the next acknowledge.
  - Address and word are snapshotted at acceptance. A later load_start or nonce_inc does not alter a word already acknowledged.
- Nonce:
  - nonce_inc adds 1 mod 2^32. On 0xFFFFFFFF -> 0, nonce_wrap sets and stays set until load_start or rst.
  - nonce_inc in the same cycle as a request acceptance: the served word 19 uses the pre-increment value.
  - Priority when simultaneous: a nonce-byte load write beats nonce_inc; load_start beats nonce_inc (the increment is dropped).
- Mid-operation load_start: hdr_valid drops the next cycle. Requests are stalled in S_IDLE until the reload completes. An in-progress S_ACK/S_WAITLOW sequence finishes normally.
- Reset mid-request: rdy drops asynchronously. The FSM returns to S_IDLE and requests stall until a new load completes.

Test Plan:
- Load bytes 0x00..0x4F, then rq with addr=0 -> rdy one cycle later with data=0x00010203. addr=18 -> 0x48494A4B. addr=19 -> nonce=0x4C4D4E4F.
- After load, request addr 20, 25, 31 -> 0x80000000, 0x00000000, 0x00000280, one rdy pulse each. Holding rq high gives no second rdy until rq drops.
- rq with addr=5 before load completes -> no rdy. After byte 79, rdy asserts two cycles later with the correct word 5.
- Load with nonce bytes FF FF FF FE, pulse nonce_inc twice -> nonce=0x00000000 and nonce_wrap=1. Then load_start -> nonce_wrap=0.
- nonce_inc in the same cycle as accepting addr=19 with nonce=0x00000007 -> data=0x00000007 and nonce=0x00000008 afterwards.
- Assert rst during S_ACK -> rdy=0 and hdr_valid=0 immediately. After release, rq with addr=0 stalls until a full reload.

Source files
------------

// File: rtl/header_word_feeder_if.sv
// Word request bus between the SHA-256 core (master) and the header feeder (slave).
// The core raises rq with addr; the feeder answers with a one-cycle rdy and holds data.
interface header_word_feeder_if;
  logic        rq;
  logic [4:0]  addr;
  logic [31:0] data;
  logic        rdy;

  modport master (output rq, output addr, input data, input rdy);
  modport slave  (input rq, input addr, output data, output rdy);
endinterface

// File: rtl/header_word_feeder.sv
// Buffers an 80-byte block header and serves the padded 640-bit message word by word,
// with word NONCE_WORD taken from a live nonce counter instead of header storage.
module header_word_feeder #(
  parameter int NONCE_WORD = 19,
  parameter int MSG_BITS   = 640
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_start,
  input  logic                 load_valid,
  input  logic [7:0]           load_byte,
  output logic                 hdr_valid,
  header_word_feeder_if.slave  bus,
  input  logic                 nonce_inc,
  output logic [31:0]          nonce,
  output logic                 nonce_wrap
);

  localparam logic [6:0] HDR_BYTES   = 7'd80;
  localparam logic [6:0] LAST_BYTE   = 7'd79;
  localparam logic [6:0] NONCE_BYTE0 = 7'd76;
  localparam logic [4:0] NONCE_ADDR  = 5'(NONCE_WORD);
  localparam logic [4:0] LAST_STORED = 5'd18;
  localparam logic [4:0] PAD_ADDR    = 5'd20;
  localparam logic [4:0] LEN_ADDR    = 5'd31;

  typedef enum logic [1:0] {S_IDLE, S_ACK, S_WAITLOW} state_t;

  logic [31:0] hdr_mem [0:18];

  logic [6:0]  count_reg, count_next;
  logic [6:0]  wr_idx;
  logic        wr_en;
  logic [4:0]  lane_lsb;
  logic        hdr_valid_reg, hdr_valid_next;
  logic [31:0] nonce_reg, nonce_next;
  logic        nonce_wrap_reg, nonce_wrap_next;
  state_t      state_reg, state_next;
  logic [31:0] data_reg, data_next;
  logic [31:0] word_sel;

  // load_start restarts at byte 0 and may carry that byte in the same cycle
  always_comb begin
    wr_idx   = load_start ? 7'd0 : count_reg;
    wr_en    = load_valid && (wr_idx < HDR_BYTES);
    lane_lsb = {~wr_idx[1:0], 3'b000};

    count_next = count_reg;
    if (load_start)
      count_next = 7'd0;
    if (wr_en)
      count_next = wr_idx + 7'd1;

    hdr_valid_next = hdr_valid_reg;
    if (load_start)
      hdr_valid_next = 1'b0;
    if (wr_en && wr_idx == LAST_BYTE)
      hdr_valid_next = 1'b1;

    nonce_next      = nonce_reg;
    nonce_wrap_next = nonce_wrap_reg;
    if (wr_en && wr_idx >= NONCE_BYTE0) begin
      nonce_next[lane_lsb +: 8] = load_byte;
    end else if (!load_start && nonce_inc) begin
      nonce_next = nonce_reg + 32'd1;
      if (nonce_reg == 32'hFFFF_FFFF)
        nonce_wrap_next = 1'b1;
    end
    if (load_start)
      nonce_wrap_next = 1'b0;
  end

  // Header storage is deliberately left out of reset
  always_ff @(posedge clk) begin
    if (wr_en && wr_idx < NONCE_BYTE0)
      hdr_mem[wr_idx[6:2]][lane_lsb +: 8] <= load_byte;
  end

  always_comb begin
    if (bus.addr == NONCE_ADDR)
      word_sel = nonce_reg;
    else if (bus.addr <= LAST_STORED)
      word_sel = hdr_mem[bus.addr];
    else if (bus.addr == PAD_ADDR)
      word_sel = 32'h8000_0000;
    else if (bus.addr == LEN_ADDR)
      word_sel = 32'(MSG_BITS);
    else
      word_sel = 32'h0000_0000;
  end

  always_comb begin
    state_next = state_reg;
    data_next  = data_reg;
    case (state_reg)
      S_IDLE: begin
        if (bus.rq && hdr_valid_reg) begin
          data_next  = word_sel;
          state_next = S_ACK;
        end
      end
      S_ACK:     state_next = S_WAITLOW;
      S_WAITLOW: if (!bus.rq) state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg      <= 7'd0;
      hdr_valid_reg  <= 1'b0;
      nonce_reg      <= 32'd0;
      nonce_wrap_reg <= 1'b0;
      state_reg      <= S_IDLE;
      data_reg       <= 32'd0;
    end else begin
      count_reg      <= count_next;
      hdr_valid_reg  <= hdr_valid_next;
      nonce_reg      <= nonce_next;
      nonce_wrap_reg <= nonce_wrap_next;
      state_reg      <= state_next;
      data_reg       <= data_next;
    end
  end

  assign bus.rdy    = (state_reg == S_ACK);
  assign bus.data   = data_reg;
  assign hdr_valid  = hdr_valid_reg;
  assign nonce      = nonce_reg;
  assign nonce_wrap = nonce_wrap_reg;

endmodule

// File: tb/tb_header_word_feeder.sv
// Randomized self-checking bench for header_word_feeder against a byte-array model
// of the header, nonce counter and padded message word map.
module tb_header_word_feeder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_start = 1'b0;
  logic        load_valid = 1'b0;
  logic [7:0]  load_byte = 8'd0;
  logic        hdr_valid;
  logic        nonce_inc = 1'b0;
  logic [31:0] nonce;
  logic        nonce_wrap;

  header_word_feeder_if bus();

  header_word_feeder dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .load_valid (load_valid),
    .load_byte  (load_byte),
    .hdr_valid  (hdr_valid),
    .bus        (bus),
    .nonce_inc  (nonce_inc),
    .nonce      (nonce),
    .nonce_wrap (nonce_wrap)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]  model_bytes [0:79];
  logic [31:0] model_nonce = 32'd0;
  logic        model_wrap = 1'b0;

  function automatic logic [31:0] model_word(input logic [4:0] a);
    int w;
    w = int'(a);
    if (w == 19) return model_nonce;
    if (w < 19)  return {model_bytes[4*w], model_bytes[4*w+1], model_bytes[4*w+2], model_bytes[4*w+3]};
    if (w == 20) return 32'h8000_0000;
    if (w == 31) return 32'd640;
    return 32'd0;
  endfunction

  task automatic model_inc();
    if (model_nonce == 32'hFFFF_FFFF) model_wrap = 1'b1;
    model_nonce = model_nonce + 32'd1;
  endtask

  task automatic randomize_bytes();
    for (int i = 0; i < 80; i++) model_bytes[i] = 8'($urandom);
  endtask

  // Streams model_bytes[0..n-1]; optionally pulses nonce_inc alongside byte inc_at
  task automatic load_bytes(input int n, input int inc_at);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      load_start = (i == 0);
      load_valid = 1'b1;
      load_byte  = model_bytes[i];
      nonce_inc  = (i == inc_at);
    end
    @(negedge clk);
    load_start = 1'b0;
    load_valid = 1'b0;
    nonce_inc  = 1'b0;
    if (n == 80) begin
      model_nonce = {model_bytes[76], model_bytes[77], model_bytes[78], model_bytes[79]};
      model_wrap  = 1'b0;
    end
  endtask

  task automatic do_request(input logic [4:0] a, input bit inc, input int hold,
                            output bit got, output int lat, output logic [31:0] d,
                            output int extra, output logic [31:0] d_after);
    @(negedge clk);
    bus.rq    = 1'b1;
    bus.addr  = a;
    nonce_inc = inc;
    got = 1'b0; lat = 0; d = 32'd0; extra = 0;
    while (!got && lat < 8) begin
      @(negedge clk);
      nonce_inc = 1'b0;
      lat++;
      if (bus.rdy === 1'b1) begin
        got = 1'b1;
        d   = bus.data;
      end
    end
    nonce_inc = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (bus.rdy === 1'b1) extra++;
    end
    bus.rq = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (bus.rdy === 1'b1) extra++;
    end
    d_after = bus.data;
    $display("req addr=%0d inc=%0d hold=%0d -> rdy=%0d lat=%0d data=%08h", a, inc, hold, got, lat, d);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (bus.rdy !== 1'b0)      begin errors++; $display("FAIL reset_rdy: got %b expected 0", bus.rdy); end
    checks++; if (bus.data !== 32'd0)    begin errors++; $display("FAIL reset_data: got %08h expected 00000000", bus.data); end
    checks++; if (hdr_valid !== 1'b0)    begin errors++; $display("FAIL reset_hdr_valid: got %b expected 0", hdr_valid); end
    checks++; if (nonce !== 32'd0)       begin errors++; $display("FAIL reset_nonce: got %08h expected 00000000", nonce); end
    checks++; if (nonce_wrap !== 1'b0)   begin errors++; $display("FAIL reset_wrap: got %b expected 0", nonce_wrap); end
    rst = 1'b0;
  endtask

  task automatic test_fixed_load();
    logic [4:0] addrs [3];
    logic [31:0] want [3];
    bit got; int lat; int extra; logic [31:0] d; logic [31:0] d_after;
    addrs = '{5'd0, 5'd18, 5'd19};
    want  = '{32'h00010203, 32'h48494A4B, 32'h4C4D4E4F};
    for (int i = 0; i < 80; i++) model_bytes[i] = 8'(i);
    load_bytes(80, -1);
    checks++; if (hdr_valid !== 1'b1) begin errors++; $display("FAIL fixed_hdr_valid: got %b expected 1", hdr_valid); end
    for (int k = 0; k < 3; k++) begin
      do_request(addrs[k], 1'b0, 0, got, lat, d, extra, d_after);
      checks++; if (!got || lat != 1) begin errors++; $display("FAIL fixed_latency addr=%0d: got rdy=%0d lat=%0d expected rdy=1 lat=1", addrs[k], got, lat); end
      checks++; if (d !== want[k])    begin errors++; $display("FAIL fixed_data addr=%0d: got %08h expected %08h", addrs[k], d, want[k]); end
      checks++; if (d_after !== want[k] || extra != 0) begin errors++; $display("FAIL fixed_hold addr=%0d: data after %08h extra rdy %0d expected %08h and 0", addrs[k], d_after, extra, want[k]); end
    end
  endtask

  task automatic test_padding();
    logic [4:0] addrs [3];
    bit got; int lat; int extra; logic [31:0] d; logic [31:0] d_after;
    addrs = '{5'd20, 5'd25, 5'd31};
    for (int k = 0; k < 3; k++) begin
      do_request(addrs[k], 1'b0, 5, got, lat, d, extra, d_after);
      checks++; if (!got || lat != 1) begin errors++; $display("FAIL pad_latency addr=%0d: got rdy=%0d lat=%0d expected rdy=1 lat=1", addrs[k], got, lat); end
      checks++; if (d !== model_word(addrs[k])) begin errors++; $display("FAIL pad_data addr=%0d: got %08h expected %08h", addrs[k], d, model_word(addrs[k])); end
      checks++; if (extra != 0) begin errors++; $display("FAIL pad_single_rdy addr=%0d: got %0d extra rdy expected 0", addrs[k], extra); end
    end
  endtask

  task automatic test_stall();
    int early;
    randomize_bytes();
    load_bytes(79, -1);
    checks++; if (hdr_valid !== 1'b0) begin errors++; $display("FAIL stall_hdr_valid_partial: got %b expected 0", hdr_valid); end
    @(negedge clk);
    bus.rq = 1'b1; bus.addr = 5'd5;
    early = 0;
    repeat (4) begin @(negedge clk); if (bus.rdy === 1'b1) early++; end
    checks++; if (early != 0) begin errors++; $display("FAIL stall_no_rdy: got %0d rdy pulses expected 0", early); end
    load_valid = 1'b1; load_byte = model_bytes[79];
    @(negedge clk);
    load_valid = 1'b0;
    model_nonce = {model_bytes[76], model_bytes[77], model_bytes[78], model_bytes[79]};
    checks++; if (bus.rdy !== 1'b0 || hdr_valid !== 1'b1) begin errors++; $display("FAIL stall_after_byte79: got rdy=%b hdr_valid=%b expected 0 and 1", bus.rdy, hdr_valid); end
    @(negedge clk);
    checks++; if (bus.rdy !== 1'b1 || bus.data !== model_word(5'd5)) begin errors++; $display("FAIL stall_release: got rdy=%b data=%08h expected 1 and %08h", bus.rdy, bus.data, model_word(5'd5)); end
    bus.rq = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_random_requests();
    logic [4:0] a; bit inc; int hold; logic [31:0] exp;
    bit got; int lat; int extra; logic [31:0] d; logic [31:0] d_after;
    randomize_bytes();
    load_bytes(80, -1);
    for (int t = 0; t < 24; t++) begin
      a    = 5'($urandom_range(0, 31));
      inc  = ($urandom_range(0, 2) == 0);
      hold = $urandom_range(0, 3);
      exp  = model_word(a);
      if (inc) model_inc();
      do_request(a, inc, hold, got, lat, d, extra, d_after);
      checks++; if (!got || lat != 1) begin errors++; $display("FAIL rand_latency addr=%0d: got rdy=%0d lat=%0d expected rdy=1 lat=1", a, got, lat); end
      checks++; if (d !== exp)        begin errors++; $display("FAIL rand_data addr=%0d: got %08h expected %08h", a, d, exp); end
      checks++; if (extra != 0 || d_after !== exp) begin errors++; $display("FAIL rand_hold addr=%0d: extra rdy %0d data after %08h expected 0 and %08h", a, extra, d_after, exp); end
    end
    checks++; if (nonce !== model_nonce) begin errors++; $display("FAIL rand_nonce: got %08h expected %08h", nonce, model_nonce); end
  endtask

  task automatic test_nonce_wrap();
    randomize_bytes();
    model_bytes[76] = 8'hFF; model_bytes[77] = 8'hFF; model_bytes[78] = 8'hFF; model_bytes[79] = 8'hFE;
    load_bytes(80, -1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); nonce_inc = 1'b1;
      @(negedge clk); nonce_inc = 1'b0;
      model_inc();
      $display("nonce_inc %0d -> nonce=%08h wrap=%b", i, nonce, nonce_wrap);
      checks++; if (nonce !== model_nonce || nonce_wrap !== model_wrap) begin errors++; $display("FAIL wrap_step%0d: got nonce=%08h wrap=%b expected %08h and %b", i, nonce, nonce_wrap, model_nonce, model_wrap); end
    end
    // load_start together with nonce_inc: wrap cleared, increment dropped
    @(negedge clk); load_start = 1'b1; nonce_inc = 1'b1;
    @(negedge clk); load_start = 1'b0; nonce_inc = 1'b0;
    model_wrap = 1'b0;
    checks++; if (nonce_wrap !== 1'b0 || hdr_valid !== 1'b0) begin errors++; $display("FAIL wrap_cleared: got wrap=%b hdr_valid=%b expected 0 and 0", nonce_wrap, hdr_valid); end
    checks++; if (nonce !== model_nonce) begin errors++; $display("FAIL start_beats_inc: got %08h expected %08h", nonce, model_nonce); end
    // nonce_inc on the cycle byte 79 lands: the byte write wins
    randomize_bytes();
    load_bytes(80, 79);
    checks++; if (nonce !== model_nonce) begin errors++; $display("FAIL write_beats_inc: got %08h expected %08h", nonce, model_nonce); end
  endtask

  task automatic test_inc_same_cycle();
    bit got; int lat; int extra; logic [31:0] d; logic [31:0] d_after;
    randomize_bytes();
    model_bytes[76] = 8'h00; model_bytes[77] = 8'h00; model_bytes[78] = 8'h00; model_bytes[79] = 8'h07;
    load_bytes(80, -1);
    do_request(5'd19, 1'b1, 0, got, lat, d, extra, d_after);
    checks++; if (!got || d !== 32'h0000_0007) begin errors++; $display("FAIL inc_same_data: got rdy=%0d data=%08h expected 1 and 00000007", got, d); end
    checks++; if (nonce !== 32'h0000_0008) begin errors++; $display("FAIL inc_same_nonce: got %08h expected 00000008", nonce); end
    model_nonce = 32'h0000_0008;
  endtask

  task automatic test_reset_mid_request();
    int stalled;
    bit got; int lat; int extra; logic [31:0] d; logic [31:0] d_after;
    @(negedge clk); bus.rq = 1'b1; bus.addr = 5'd0;
    @(negedge clk);
    checks++; if (bus.rdy !== 1'b1) begin errors++; $display("FAIL mid_ack_reached: got rdy=%b expected 1", bus.rdy); end
    #1 rst = 1'b1;
    #1;
    checks++; if (bus.rdy !== 1'b0 || hdr_valid !== 1'b0 || nonce !== 32'd0) begin errors++; $display("FAIL mid_async_reset: got rdy=%b hdr_valid=%b nonce=%08h expected 0 0 00000000", bus.rdy, hdr_valid, nonce); end
    @(negedge clk); rst = 1'b0;
    model_nonce = 32'd0; model_wrap = 1'b0;
    stalled = 0;
    repeat (5) begin @(negedge clk); if (bus.rdy === 1'b1) stalled++; end
    checks++; if (stalled != 0) begin errors++; $display("FAIL mid_stall: got %0d rdy pulses expected 0", stalled); end
    bus.rq = 1'b0;
    load_bytes(80, -1);
    do_request(5'd0, 1'b0, 0, got, lat, d, extra, d_after);
    checks++; if (!got || lat != 1 || d !== model_word(5'd0)) begin errors++; $display("FAIL mid_reload: got rdy=%0d lat=%0d data=%08h expected 1 1 %08h", got, lat, d, model_word(5'd0)); end
  endtask

  initial begin
    bus.rq   = 1'b0;
    bus.addr = 5'd0;
    test_reset();
    test_fixed_load();
    test_padding();
    test_stall();
    test_random_requests();
    test_nonce_wrap();
    test_inc_same_cycle();
    test_reset_mid_request();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
